// File: rtl/alu_result_sequencer.sv
// Sequencer for the ALU result mux: takes one op at a time, drives the select code,
// handshakes multi-cycle units (with timeout) and holds the result until it is consumed.
module alu_result_sequencer #(
    parameter int unsigned size       = 8,
    parameter logic [6:0]  MULTI_MASK = 7'b0001000,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [2:0]      op_idx,
    input  logic [size-1:0] op_a,
    input  logic [size-1:0] op_b,
    output logic [size-1:0] opnd_a,
    output logic [size-1:0] opnd_b,
    output logic [2:0]      mux_sel,
    output logic            unit_start,
    input  logic            unit_done,
    input  logic [size-1:0] mux_out,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [size-1:0] res_data,
    output logic [2:0]      res_idx,
    output logic            err_illegal,
    output logic            err_timeout
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    // Index 7 padded in so the mask can be indexed directly by a 3-bit op index.
    localparam logic [7:0] MULTI8   = {1'b0, MULTI_MASK};
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    function automatic logic [2:0] sel_code(input logic [2:0] idx);
        case (idx)
            3'd0:    sel_code = 3'b000;
            3'd1:    sel_code = 3'b001;
            3'd2:    sel_code = 3'b011;
            3'd3:    sel_code = 3'b100;
            3'd4:    sel_code = 3'b110;
            3'd5:    sel_code = 3'b101;
            3'd6:    sel_code = 3'b111;
            default: sel_code = 3'b000;
        endcase
    endfunction

    logic [1:0]      state_q, state_d;
    logic            op_ready_q, op_ready_d;
    logic [2:0]      idx_q, idx_d;
    logic [2:0]      mux_sel_q, mux_sel_d;
    logic [size-1:0] opnd_a_q, opnd_a_d;
    logic [size-1:0] opnd_b_q, opnd_b_d;
    logic            unit_start_q, unit_start_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            res_valid_q, res_valid_d;
    logic [size-1:0] res_data_q, res_data_d;
    logic [2:0]      res_idx_q, res_idx_d;
    logic            err_illegal_q, err_illegal_d;
    logic            err_timeout_q, err_timeout_d;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        mux_sel_d     = mux_sel_q;
        opnd_a_d      = opnd_a_q;
        opnd_b_d      = opnd_b_q;
        unit_start_d  = 1'b0;
        cnt_d         = cnt_q;
        res_valid_d   = res_valid_q;
        res_data_d    = res_data_q;
        res_idx_d     = res_idx_q;
        err_illegal_d = 1'b0;
        err_timeout_d = err_timeout_q;
        case (state_q)
            S_IDLE: begin
                if (op_valid && op_ready_q) begin
                    if (op_idx == 3'd7) begin
                        err_illegal_d = 1'b1;
                    end else begin
                        idx_d        = op_idx;
                        mux_sel_d    = sel_code(op_idx);
                        opnd_a_d     = op_a;
                        opnd_b_d     = op_b;
                        unit_start_d = MULTI8[op_idx];
                        state_d      = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                if (MULTI8[idx_q]) begin
                    cnt_d   = 8'd0;
                    state_d = S_WAIT;
                end else begin
                    res_data_d    = mux_out;
                    res_idx_d     = idx_q;
                    res_valid_d   = 1'b1;
                    err_timeout_d = 1'b0;
                    state_d       = S_HOLD;
                end
            end
            S_WAIT: begin
                if (unit_done) begin
                    res_data_d    = mux_out;
                    res_idx_d     = idx_q;
                    res_valid_d   = 1'b1;
                    err_timeout_d = 1'b0;
                    state_d       = S_HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    // Abort: an all-zero result flagged by err_timeout.
                    res_data_d    = '0;
                    res_idx_d     = idx_q;
                    res_valid_d   = 1'b1;
                    err_timeout_d = 1'b1;
                    state_d       = S_HOLD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                if (res_ready) begin
                    res_valid_d   = 1'b0;
                    err_timeout_d = 1'b0;
                    state_d       = S_IDLE;
                end
            end
        endcase
        // Registered so it reads 0 while in reset and rises on the first edge after.
        op_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            op_ready_q    <= 1'b0;
            idx_q         <= 3'd0;
            mux_sel_q     <= 3'b000;
            opnd_a_q      <= '0;
            opnd_b_q      <= '0;
            unit_start_q  <= 1'b0;
            cnt_q         <= 8'd0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_idx_q     <= 3'd0;
            err_illegal_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_ready_q    <= op_ready_d;
            idx_q         <= idx_d;
            mux_sel_q     <= mux_sel_d;
            opnd_a_q      <= opnd_a_d;
            opnd_b_q      <= opnd_b_d;
            unit_start_q  <= unit_start_d;
            cnt_q         <= cnt_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_idx_q     <= res_idx_d;
            err_illegal_q <= err_illegal_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign op_ready    = op_ready_q;
    assign mux_sel     = mux_sel_q;
    assign opnd_a      = opnd_a_q;
    assign opnd_b      = opnd_b_q;
    assign unit_start  = unit_start_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_idx     = res_idx_q;
    assign err_illegal = err_illegal_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_alu_result_sequencer.sv
// Bench for alu_result_sequencer: transaction-level model (accept cycle -> result cycle
// arithmetic) compared every cycle, directed literal checks, then randomized traffic.
module tb_alu_result_sequencer;
    localparam int         TO = 16;
    localparam logic [7:0] MM = 8'b0000_1000;

    logic       clk = 1'b0, rst_n = 1'b1;
    logic       op_valid = 1'b0, op_ready;
    logic [2:0] op_idx = 3'd0;
    logic [7:0] op_a = 8'h00, op_b = 8'h00, opnd_a, opnd_b;
    logic [2:0] mux_sel;
    logic       unit_start, unit_done = 1'b0;
    logic [7:0] mux_out;
    logic       res_valid, res_ready = 1'b0;
    logic [7:0] res_data;
    logic [2:0] res_idx;
    logic       err_illegal, err_timeout;

    int n_chk = 0, n_pass = 0;

    // Side-band presented with each request; latched by the model on accept.
    int         req_dly = 0, cur_dly = 0;
    logic [7:0] req_uval = 8'h00, cur_uval = 8'h00;

    alu_result_sequencer #(.size(8), .MULTI_MASK(7'b0001000), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_idx(op_idx), .op_a(op_a), .op_b(op_b), .opnd_a(opnd_a), .opnd_b(opnd_b),
        .mux_sel(mux_sel), .unit_start(unit_start), .unit_done(unit_done),
        .mux_out(mux_out), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_idx(res_idx), .err_illegal(err_illegal),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Functional units behind the mux; code 100 is the multi-cycle unit.
    function automatic logic [7:0] alu_f(input logic [2:0] c, input logic [7:0] a, b, u);
        case (c)
            3'b000:  alu_f = a + b;
            3'b001:  alu_f = a & b;
            3'b011:  alu_f = a - b;
            3'b100:  alu_f = u;
            3'b110:  alu_f = a | b;
            3'b101:  alu_f = a ^ b;
            3'b111:  alu_f = ~a;
            default: alu_f = 8'hEE;
        endcase
    endfunction

    function automatic logic [2:0] code_of(input logic [2:0] i);
        case (i)
            3'd0: code_of = 3'b000;  3'd1: code_of = 3'b001;
            3'd2: code_of = 3'b011;  3'd3: code_of = 3'b100;
            3'd4: code_of = 3'b110;  3'd5: code_of = 3'b101;
            3'd6: code_of = 3'b111;  default: code_of = 3'b010;
        endcase
    endfunction

    assign mux_out = alu_f(mux_sel, opnd_a, opnd_b, cur_uval);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Multi-cycle unit: done in the dly-th cycle after the start pulse (dly=0: never).
    int wcnt = 0, n_start = 0;
    bit armed = 0, noise_en = 0;
    always @(negedge clk) begin
        if (unit_start) begin armed = 1; wcnt = 0; n_start++; end
        else if (armed) wcnt++;
        unit_done = 1'b0;
        if (armed && wcnt != 0 && wcnt == cur_dly) begin unit_done = 1'b1; armed = 0; end
        else if (armed && wcnt > TO + 2) armed = 0;
        else if (!armed && noise_en) unit_done = ($urandom_range(0, 7) == 0);
    end

    // Reference model: a request accepted at edge n yields its result at a computed edge.
    bit         busy = 0, m_acc = 0, p_to = 0;
    int         cyc = 0, v_edge = 0;
    logic [7:0] p_data = 8'h00;
    logic [2:0] p_idx = 3'd0;
    logic       e_ready = 0, e_start = 0, e_res_valid = 0, e_err_ill = 0, e_err_to = 0;
    logic [2:0] e_mux_sel = 3'd0, e_res_idx = 3'd0;
    logic [7:0] e_opa = 8'h00, e_opb = 8'h00, e_res_data = 8'h00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy = 0; m_acc = 0; e_ready = 0; e_start = 0; e_res_valid = 0;
            e_err_ill = 0; e_err_to = 0; e_mux_sel = 3'd0; e_res_idx = 3'd0;
            e_opa = 8'h00; e_opb = 8'h00; e_res_data = 8'h00;
        end else begin
            m_acc = 0; e_err_ill = 0; e_start = 0;
            if (!busy) begin
                if (e_ready && op_valid) begin
                    m_acc = 1;
                    if (op_idx == 3'd7) e_err_ill = 1;
                    else begin
                        busy = 1; p_idx = op_idx;
                        e_mux_sel = code_of(op_idx); e_opa = op_a; e_opb = op_b;
                        cur_uval = req_uval; cur_dly = req_dly;
                        if (MM[op_idx]) begin
                            e_start = 1;
                            if (req_dly >= 1 && req_dly <= TO) begin
                                v_edge = cyc + 1 + req_dly; p_data = req_uval; p_to = 0;
                            end else begin
                                v_edge = cyc + 1 + TO; p_data = 8'h00; p_to = 1;
                            end
                        end else begin
                            v_edge = cyc + 1; p_to = 0;
                            p_data = alu_f(code_of(op_idx), op_a, op_b, 8'h00);
                        end
                    end
                end
            end else if (!e_res_valid) begin
                if (cyc == v_edge) begin
                    e_res_valid = 1; e_res_data = p_data; e_res_idx = p_idx; e_err_to = p_to;
                end
            end else if (res_ready) begin
                e_res_valid = 0; e_err_to = 0; busy = 0;
            end
            e_ready = !busy;
            cyc++;
        end
    end

    always @(negedge clk) begin
        chk("op_ready", op_ready, e_ready);
        chk("mux_sel", mux_sel, e_mux_sel);
        chk("mux_sel_not_010", mux_sel == 3'b010, 1'b0);
        chk("opnd_a", opnd_a, e_opa);
        chk("opnd_b", opnd_b, e_opb);
        chk("unit_start", unit_start, e_start);
        chk("res_valid", res_valid, e_res_valid);
        chk("res_data", res_data, e_res_data);
        chk("res_idx", res_idx, e_res_idx);
        chk("err_illegal", err_illegal, e_err_ill);
        chk("err_timeout", err_timeout, e_err_to);
    end

    task automatic send(input logic [2:0] idx, input logic [7:0] a, b, input int dly,
                        input logic [7:0] uv);
        int n;
        #2;
        op_idx = idx; op_a = a; op_b = b; req_dly = dly; req_uval = uv; op_valid = 1'b1;
        n = 0;
        while (!op_ready && n < 100) begin @(negedge clk); #2; n++; end
        if (!op_ready) chk("accept_wait_expired", 1'b0, 1'b1);
        @(negedge clk); #2;
        op_valid = 1'b0;
    endtask

    task automatic wait_res(output int lat);
        lat = 0;
        while (!res_valid && lat < 60) begin @(negedge clk); #2; lat++; end
        if (!res_valid) chk("result_wait_expired", 1'b0, 1'b1);
    endtask

    logic [20:0] codes_lit = 21'b111_101_110_100_011_001_000;
    int lat;

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_op_ready", op_ready, 1'b0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_mux_sel", mux_sel, 3'b000);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk); #2;
        chk("ready_after_reset", op_ready, 1'b1);
        res_ready = 1'b1;

        // a - b through code 011
        send(3'd2, 8'h05, 8'h03, 0, 8'h00);
        chk("t1_mux_sel", mux_sel, 3'b011);
        wait_res(lat);
        chk("t1_latency", lat, 1);
        chk("t1_res_data", res_data, 8'h02);
        chk("t1_res_idx", res_idx, 3'd2);
        @(negedge clk); #2;
        chk("t1_ready_after_hs", op_ready, 1'b1);
        chk("t1_valid_dropped", res_valid, 1'b0);

        for (int i = 0; i < 7; i++) begin
            send(3'(i), 8'h3C, 8'h0F, 3, 8'h5A);
            chk("sweep_mux_sel", mux_sel, codes_lit[3*i +: 3]);
            wait_res(lat);
            @(negedge clk); #2;
        end

        n_start = 0;
        send(3'd3, 8'h01, 8'h02, 4, 8'hC8);
        wait_res(lat);
        chk("mc_latency", lat, 5);
        chk("mc_res_data", res_data, 8'hC8);
        chk("mc_err_timeout", err_timeout, 1'b0);
        chk("mc_start_pulses", n_start, 1);
        @(negedge clk); #2;

        send(3'd3, 8'h01, 8'h02, 0, 8'hAB);
        wait_res(lat);
        chk("to_latency", lat, 17);
        chk("to_res_data", res_data, 8'h00);
        chk("to_err_timeout", err_timeout, 1'b1);
        chk("to_res_idx", res_idx, 3'd3);
        @(negedge clk); #2;
        chk("to_err_cleared", err_timeout, 1'b0);

        send(3'd7, 8'h12, 8'h34, 0, 8'h00);
        chk("ill_pulse", err_illegal, 1'b1);
        chk("ill_ready", op_ready, 1'b1);
        @(negedge clk); #2;
        chk("ill_pulse_end", err_illegal, 1'b0);
        chk("ill_no_result", res_valid, 1'b0);

        res_ready = 1'b0;
        send(3'd1, 8'hF0, 8'h3C, 0, 8'h00);
        wait_res(lat);
        op_valid = 1'b1; op_idx = 3'd4;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #2;
            chk("bp_res_data", res_data, 8'h30);
            chk("bp_op_ready", op_ready, 1'b0);
            chk("bp_res_valid", res_valid, 1'b1);
        end
        op_valid = 1'b0; res_ready = 1'b1;
        @(negedge clk); #2;
        chk("bp_released", res_valid, 1'b0);

        send(3'd3, 8'h11, 8'h22, 0, 8'h77);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_op_ready", op_ready, 1'b0);
        chk("mr_mux_sel", mux_sel, 3'b000);
        chk("mr_opnd_a", opnd_a, 8'h00);
        chk("mr_opnd_b", opnd_b, 8'h00);
        chk("mr_res_data", res_data, 8'h00);
        chk("mr_res_valid", res_valid, 1'b0);
        @(negedge clk); #2 rst_n = 1'b1;
        @(negedge clk);

        noise_en = 1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #2;
            res_ready = ($urandom_range(0, 3) != 0);
            if (!op_valid || m_acc) begin
                int r;
                op_valid = ($urandom_range(0, 2) != 0);
                op_idx = ($urandom_range(0, 9) < 3) ? 3'd3 : 3'($urandom_range(0, 7));
                op_a = 8'($urandom); op_b = 8'($urandom);
                r = $urandom_range(0, 5);
                req_dly = (r == 0) ? 0 : (r == 1) ? TO : $urandom_range(1, TO - 1);
                req_uval = 8'($urandom);
            end
        end
        op_valid = 1'b0; res_ready = 1'b1;
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
